// File: rtl/axis_pkg.sv
// axis_pkg: shared types for the AXI-Stream register slice.
package axis_pkg;
    typedef enum logic {STAGE_SKID, STAGE_SINGLE} stage_mode_t;
    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} stage_state_t;
    typedef logic [31:0] axis_data_t;
endpackage

// File: rtl/axis_if.sv
// axis_if: valid/ready/data stream link.
interface axis_if #(parameter type data_t = logic [31:0]);
    logic  valid;
    logic  ready;
    data_t data;
    modport master (output valid, output data, input ready);
    modport slave (input valid, input data, output ready);
endinterface

// File: rtl/axis_reg_stage.sv
// axis_reg_stage: one registered stream stage, either a 2-entry skid buffer or a 1-entry half-rate register.
module axis_reg_stage
    import axis_pkg::*;
#(
    parameter type         data_t = axis_data_t,
    parameter stage_mode_t MODE   = STAGE_SKID
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  i_valid,
    output logic  o_ready,
    input  data_t i_data,
    output logic  o_valid,
    input  logic  i_ready,
    output data_t o_data
);
    stage_state_t r_state, w_next;
    data_t        r_main, r_skid;
    logic         w_in_xfer, w_out_xfer, w_load_main, w_load_skid, w_main_sel_skid;

    // ready comes only from registered state, never from i_ready
    assign o_ready    = ~rst & (MODE == STAGE_SKID ? r_state != S_FULL : r_state == S_EMPTY);
    assign o_valid    = r_state != S_EMPTY;
    assign o_data     = r_main;
    assign w_in_xfer  = i_valid & o_ready;
    assign w_out_xfer = o_valid & i_ready;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_EMPTY;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (w_load_main) r_main <= w_main_sel_skid ? r_skid : i_data;
        if (w_load_skid) r_skid <= i_data;
    end

    always_comb begin
        w_next          = r_state;
        w_load_main     = 1'b0;
        w_load_skid     = 1'b0;
        w_main_sel_skid = 1'b0;
        case (r_state)
            S_EMPTY: if (w_in_xfer) begin
                w_next      = S_ONE;
                w_load_main = 1'b1;
            end
            S_ONE: begin
                if (w_in_xfer && w_out_xfer) w_load_main = 1'b1;
                else if (w_in_xfer && MODE == STAGE_SKID) begin
                    w_next      = S_FULL;
                    w_load_skid = 1'b1;
                end else if (w_out_xfer) w_next = S_EMPTY;
            end
            S_FULL: if (w_out_xfer) begin
                w_next          = S_ONE;
                w_load_main     = 1'b1;
                w_main_sel_skid = 1'b1;
            end
            default: w_next = S_EMPTY;
        endcase
    end
endmodule

// File: rtl/axis_reg_slice.sv
// axis_reg_slice: STAGES cascaded stream register stages between in and out.
// Define AXIS_REG_SLICE_STALL_CNT_EN to build the saturating out-stall counter.
module axis_reg_slice
    import axis_pkg::*;
#(
    parameter type data_t          = axis_data_t,
    parameter int  STAGES          = 2,
    parameter bit  FULL_THROUGHPUT = 1'b1,
    parameter int  STALL_CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    axis_if.slave                  in,
    axis_if.master                 out,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    localparam stage_mode_t MODE = FULL_THROUGHPUT ? STAGE_SKID : STAGE_SINGLE;

    if (STAGES == 0) begin : g_pass
        assign out.valid = in.valid;
        assign out.data  = in.data;
        assign in.ready  = out.ready;
    end else begin : g_pipe
        axis_if #(.data_t(data_t)) w_link [STAGES+1] ();
        assign w_link[0].valid    = in.valid;
        assign w_link[0].data     = in.data;
        assign in.ready           = w_link[0].ready;
        assign out.valid          = w_link[STAGES].valid;
        assign out.data           = w_link[STAGES].data;
        assign w_link[STAGES].ready = out.ready;
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            axis_reg_stage #(.data_t(data_t), .MODE(MODE)) u_stage (
                .clk     (clk),
                .rst     (rst),
                .i_valid (w_link[k].valid),
                .o_ready (w_link[k].ready),
                .i_data  (w_link[k].data),
                .o_valid (w_link[k+1].valid),
                .i_ready (w_link[k+1].ready),
                .o_data  (w_link[k+1].data)
            );
        end
    end

`ifdef AXIS_REG_SLICE_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] r_stall_cnt;
    always_ff @(posedge clk) begin
        if (rst) r_stall_cnt <= '0;
        else if (out.valid & ~out.ready & ~&r_stall_cnt) r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif
endmodule
